rf_dump_reader: RTL

- Debug/readback engine for the processor register file: the reader end of the register-file write path.
- On a start pulse it walks a programmable address range, drives the register-file read address, captures each read word, and streams it out over a valid/ready handshake with its index.
- Keeps a running 32-bit sum checksum of emitted words. Sits beside the register file, on an otherwise unused read port, driven by the debug/test controller.

---
 rtl/rf_dump_reader.sv | 84 ++++++++
 1 files changed

// File: rtl/rf_dump_reader.sv
// Register-file readback engine: walks an inclusive (possibly wrapping) address range and
// streams each word with its index over valid/ready, keeping a running sum checksum.
module rf_dump_reader #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ZERO_X0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

  state_e            state;
  logic [ADDR_W-1:0] end_q;
  logic              force_zero;

  // rf_addr doubles as the current walk address; it only moves after a handshake.
  assign force_zero = (ZERO_X0 != 0) && (rf_addr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      end_q     <= '0;
      rf_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            end_q    <= end_addr;
            rf_addr  <= start_addr;
            checksum <= '0;
            busy     <= 1'b1;
            state    <= StRead;
          end
        end
        StRead: begin
          out_data  <= force_zero ? '0 : rf_data;
          out_idx   <= rf_addr;
          out_valid <= 1'b1;
          state     <= StSend;
        end
        StSend: begin
          if (out_valid && out_ready) begin
            checksum  <= checksum + out_data;
            out_valid <= 1'b0;
            if (rf_addr == end_q) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= StDone;
            end else begin
              rf_addr <= rf_addr + 1'b1;
              state   <= StRead;
            end
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
